// File: rtl/tthbif_cal_pkg.sv
// Shared types and constants for the tthbif RX tap calibration sequencer.
// The tap code is {flop_sel, comb_sel}; helpers split it into the two selects.
package tthbif_cal_pkg;

    localparam int unsigned NUM_TAP_CODES = 16;
    localparam int unsigned TAP_CODE_W    = 4;

    // x^7 + x^6 + 1: predicted bit is hist[6] ^ hist[5]
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_MEASURE,
        S_EVAL,
        S_PICK,
        S_DONE
    } cal_state_e;

    typedef struct packed {
        logic [1:0] flop;
        logic [1:0] comb;
    } tap_sel_t;

    function automatic tap_sel_t split_code(input logic [TAP_CODE_W-1:0] code);
        tap_sel_t sel;
        sel.flop = code[3:2];
        sel.comb = code[1:0];
        return sel;
    endfunction

endpackage

// File: rtl/tthbif_tap_cal_prbs7_chk.sv
// Self-synchronising PRBS7 checker: predicts each bit from the last seven
// received bits and flags mismatches; locked once seven bits are in history.
module prbs7_chk
    import tthbif_cal_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic bit_i,
    output logic err_o,
    output logic locked_o
);

    logic [6:0] hist_q, hist_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        hist_d = {hist_q[5:0], bit_i};
        cnt_d  = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        if (flush_i) begin
            hist_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hist_q <= '0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            cnt_q  <= cnt_d;
        end
    end

    assign locked_o = (cnt_q == 3'd7);
    assign err_o    = bit_i ^ (^(hist_q & PRBS7_TAPS));

endmodule

// File: rtl/tthbif_tap_cal.sv
// Sweeps all 16 RX tap codes, scores each with a PRBS7 error window and
// drives the centre of the longest passing run onto the tthbif tap selects.
module tthbif_tap_cal
    import tthbif_cal_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned WINDOW_CYCLES = 256,
    parameter int unsigned ERR_THRESH    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  rx_bit_i,
    input  logic [1:0]            man_comb_sel_i,
    input  logic [1:0]            man_flop_sel_i,
    output logic [1:0]            rx_comb_tap_sel_o,
    output logic [1:0]            rx_flop_tap_sel_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cal_ok_o,
    output logic [TAP_CODE_W-1:0] best_code_o,
    output logic [NUM_TAP_CODES-1:0] pass_mask_o
);

    localparam int unsigned SET_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned WIN_W =
        (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned ERR_W = $clog2(WINDOW_CYCLES + 1);
    localparam int unsigned RUN_W = $clog2(NUM_TAP_CODES + 1);
    localparam logic [TAP_CODE_W-1:0] LAST_CODE =
        TAP_CODE_W'(NUM_TAP_CODES - 1);

    cal_state_e state_q, state_d;

    logic [TAP_CODE_W-1:0]    code_q, code_d;
    logic [SET_W-1:0]         set_q, set_d;
    logic [WIN_W-1:0]         win_q, win_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic [NUM_TAP_CODES-1:0] mask_q, mask_d;
    logic [TAP_CODE_W-1:0]    scan_q, scan_d;
    logic [TAP_CODE_W-1:0]    run_start_q, run_start_d;
    logic [RUN_W-1:0]         run_len_q, run_len_d;
    logic [TAP_CODE_W-1:0]    best_start_q, best_start_d;
    logic [RUN_W-1:0]         best_len_q, best_len_d;
    logic [TAP_CODE_W-1:0]    best_code_q, best_code_d;
    logic                     cal_ok_q, cal_ok_d;
    logic                     done_q, done_d;

    logic [TAP_CODE_W-1:0] run_start_n;
    logic [RUN_W-1:0]      run_len_n;

    logic chk_flush;
    logic chk_err;
    logic chk_lock;
    logic busy;

    logic [TAP_CODE_W-1:0] tap_code;
    tap_sel_t              tap_sel;

    // History only needs to be live while settling and measuring
    assign chk_flush = !(state_q == S_APPLY || state_q == S_MEASURE);

    prbs7_chk u_chk (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .flush_i  (chk_flush),
        .bit_i    (rx_bit_i),
        .err_o    (chk_err),
        .locked_o (chk_lock)
    );

    assign busy = (state_q == S_APPLY) || (state_q == S_MEASURE) ||
                  (state_q == S_EVAL)  || (state_q == S_PICK);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        set_d        = set_q;
        win_d        = win_q;
        err_d        = err_q;
        mask_d       = mask_q;
        scan_d       = scan_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        best_code_d  = best_code_q;
        cal_ok_d     = cal_ok_q;
        done_d       = 1'b0;
        run_start_n  = run_start_q;
        run_len_n    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && en_i && !abort_i) begin
                    state_d      = S_APPLY;
                    mask_d       = '0;
                    cal_ok_d     = 1'b0;
                    code_d       = '0;
                    set_d        = '0;
                    run_start_d  = '0;
                    run_len_d    = '0;
                    best_start_d = '0;
                    best_len_d   = '0;
                end
            end
            S_APPLY: begin
                if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_MEASURE;
                    win_d   = '0;
                    err_d   = '0;
                end else begin
                    set_d = set_q + SET_W'(1);
                end
            end
            S_MEASURE: begin
                if (chk_err && chk_lock && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                if (win_q == WIN_W'(WINDOW_CYCLES - 1)) begin
                    state_d = S_EVAL;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            S_EVAL: begin
                mask_d[code_q] = (32'(err_q) <= ERR_THRESH);
                if (code_q == LAST_CODE) begin
                    state_d = S_PICK;
                    scan_d  = '0;
                end else begin
                    state_d = S_APPLY;
                    code_d  = code_q + TAP_CODE_W'(1);
                    set_d   = '0;
                end
            end
            S_PICK: begin
                if (mask_q[scan_q]) begin
                    run_start_n = (run_len_q == '0) ? scan_q : run_start_q;
                    run_len_n   = run_len_q + RUN_W'(1);
                end
                run_start_d = run_start_n;
                run_len_d   = run_len_n;
                // Strictly longer only, so equal runs keep the lowest start
                if (run_len_n > best_len_q) begin
                    best_start_d = run_start_n;
                    best_len_d   = run_len_n;
                end
                if (scan_q == LAST_CODE) begin
                    state_d = S_DONE;
                end else begin
                    scan_d = scan_q + TAP_CODE_W'(1);
                end
            end
            S_DONE: begin
                if (best_len_q != '0) begin
                    best_code_d = best_start_q +
                        TAP_CODE_W'((best_len_q - RUN_W'(1)) >> 1);
                    cal_ok_d    = 1'b1;
                end else begin
                    cal_ok_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_q != S_IDLE) && (abort_i || !en_i)) begin
            state_d  = S_IDLE;
            cal_ok_d = 1'b0;
            mask_d   = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            code_q       <= '0;
            set_q        <= '0;
            win_q        <= '0;
            err_q        <= '0;
            mask_q       <= '0;
            scan_q       <= '0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            best_code_q  <= '0;
            cal_ok_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            set_q        <= set_d;
            win_q        <= win_d;
            err_q        <= err_d;
            mask_q       <= mask_d;
            scan_q       <= scan_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            best_code_q  <= best_code_d;
            cal_ok_q     <= cal_ok_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        tap_code = {man_flop_sel_i, man_comb_sel_i};
        if (busy) begin
            tap_code = code_q;
        end else if (cal_ok_q) begin
            tap_code = best_code_q;
        end
    end

    assign tap_sel           = split_code(tap_code);
    assign rx_flop_tap_sel_o = tap_sel.flop;
    assign rx_comb_tap_sel_o = tap_sel.comb;

    assign busy_o      = busy;
    assign done_o      = done_q;
    assign cal_ok_o    = cal_ok_q;
    assign best_code_o = best_code_q;
    assign pass_mask_o = mask_q;

endmodule

// File: tb/tb_tthbif_tap_cal.sv
// Directed bench for tthbif_tap_cal: PRBS7 stream with planned bit errors,
// table of sweep outcomes plus abort / reset / busy-start sequences.
module tb_tthbif_tap_cal;

    localparam int S = 16;
    localparam int W = 32;
    localparam int P = S + W + 1;
    localparam int LAT = 16 * P + 17;

    logic clk = 1'b0;
    logic rst_n, en, start, abort, rx_bit;
    logic [1:0] man_comb, man_flop;

    logic [1:0]  a_comb, a_flop, b_comb, b_flop;
    logic        a_busy, a_done, a_ok, b_busy, b_done, b_ok;
    logic [3:0]  a_best, b_best;
    logic [15:0] a_mask, b_mask;

    logic [6:0] g;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tthbif_tap_cal #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .ERR_THRESH(0)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start),
        .abort_i(abort), .rx_bit_i(rx_bit),
        .man_comb_sel_i(man_comb), .man_flop_sel_i(man_flop),
        .rx_comb_tap_sel_o(a_comb), .rx_flop_tap_sel_o(a_flop),
        .busy_o(a_busy), .done_o(a_done), .cal_ok_o(a_ok),
        .best_code_o(a_best), .pass_mask_o(a_mask)
    );

    tthbif_tap_cal #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .ERR_THRESH(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .start_i(start),
        .abort_i(abort), .rx_bit_i(rx_bit),
        .man_comb_sel_i(man_comb), .man_flop_sel_i(man_flop),
        .rx_comb_tap_sel_o(b_comb), .rx_flop_tap_sel_o(b_flop),
        .busy_o(b_busy), .done_o(b_done), .cal_ok_o(b_ok),
        .best_code_o(b_best), .pass_mask_o(b_mask)
    );

    typedef struct {
        logic [15:0] bad;
        logic [15:0] exp_mask;
        logic [3:0]  exp_best;
        logic        exp_ok;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next transmitted bit continues the recurrence from what was sent,
    // so each injected flip shows up as exactly one checker error.
    task automatic step(input bit inj);
        logic b;
        b = g[6] ^ g[5] ^ inj;
        rx_bit = b;
        g = {g[5:0], b};
        @(posedge clk);
        #1;
    endtask

    function automatic bit inj_at(input int j, input logic [15:0] bad,
                                  input int nerr0);
        int code, ph;
        code = j / P;
        ph   = j % P;
        if (code > 15 || ph < S || ph >= S + W) return 1'b0;
        if (bad[code] && (j % 5 == 0)) return 1'b1;
        if (code == 0) begin
            if (ph == S + 4  && nerr0 >= 1) return 1'b1;
            if (ph == S + 14 && nerr0 >= 2) return 1'b1;
            if (ph == S + 24 && nerr0 >= 3) return 1'b1;
        end
        return 1'b0;
    endfunction

    // lat: edges after the start edge until done_o seen; -2 when stopped
    // by abort/reset at stop_j; -1 when the budget runs out.
    task automatic sweep(input logic [15:0] bad, input int nerr0,
                         input int stop_j, input bit stop_rst,
                         input int busy_start_j, output int lat);
        lat = -1;
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        for (int j = 0; j < 1000; j++) begin
            if (j == busy_start_j) start = 1'b1;
            if (j == stop_j) begin
                if (stop_rst) rst_n = 1'b0;
                else abort = 1'b1;
            end
            step(inj_at(j, bad, nerr0));
            start = 1'b0;
            abort = 1'b0;
            rst_n = 1'b1;
            if (a_done) begin
                lat = j + 1;
                break;
            end
            if (j == stop_j) begin
                lat = -2;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        vecs[0] = '{16'h0000, 16'hFFFF, 4'd7,  1'b1};
        vecs[1] = '{16'hFC1F, 16'h03E0, 4'd7,  1'b1};
        vecs[2] = '{16'hC3E3, 16'h3C1C, 4'd11, 1'b1};
        vecs[3] = '{16'hF8F1, 16'h070E, 4'd2,  1'b1};
        vecs[4] = '{16'hFFFE, 16'h0001, 4'd0,  1'b1};
        vecs[5] = '{16'h3FFF, 16'hC000, 4'd14, 1'b1};
        vecs[6] = '{16'hFFFF, 16'h0000, 4'd14, 1'b0};

        g = 7'h7F;
        rst_n = 1'b0;
        en = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        rx_bit = 1'b0;
        man_flop = 2'd2;
        man_comb = 2'd1;
        repeat (3) step(1'b0);
        rst_n = 1'b1;
        step(1'b0);

        chk("reset busy", a_busy, 0);
        chk("reset done", a_done, 0);
        chk("reset cal_ok", a_ok, 0);
        chk("reset best", a_best, 0);
        chk("reset mask", a_mask, 0);
        chk("reset taps", {a_flop, a_comb}, 4'b1001);

        start = 1'b1;
        abort = 1'b1;
        step(1'b0);
        start = 1'b0;
        abort = 1'b0;
        chk("start+abort busy", a_busy, 0);

        for (int i = 0; i < 7; i++) begin
            sweep(vecs[i].bad, 0, -1, 1'b0, -1, lat);
            chk($sformatf("v%0d latency", i), lat, LAT);
            chk($sformatf("v%0d mask", i), a_mask, vecs[i].exp_mask);
            chk($sformatf("v%0d best", i), a_best, vecs[i].exp_best);
            chk($sformatf("v%0d cal_ok", i), a_ok, vecs[i].exp_ok);
            chk($sformatf("v%0d busy", i), a_busy, 0);
            if (vecs[i].exp_ok)
                chk($sformatf("v%0d taps", i), {a_flop, a_comb},
                    vecs[i].exp_best);
            else
                chk($sformatf("v%0d taps", i), {a_flop, a_comb},
                    {man_flop, man_comb});
            step(1'b0);
            chk($sformatf("v%0d done pulse", i), a_done, 0);
        end

        man_flop = 2'd0;
        man_comb = 2'd3;
        #1;
        chk("manual follow", {a_flop, a_comb}, 4'b0011);

        sweep(16'h0000, 2, -1, 1'b0, -1, lat);
        chk("thr2 2err latency", lat, LAT);
        chk("thr0 2err mask", a_mask, 16'hFFFE);
        chk("thr0 2err best", a_best, 8);
        chk("thr2 2err mask", b_mask, 16'hFFFF);
        chk("thr2 2err best", b_best, 7);
        step(1'b0);
        sweep(16'h0000, 3, -1, 1'b0, -1, lat);
        chk("thr2 3err mask", b_mask, 16'hFFFE);
        chk("thr2 3err best", b_best, 8);
        step(1'b0);

        sweep(16'h0000, 0, 6 * P + S + 5, 1'b0, -1, lat);
        chk("abort stop", lat, -2);
        chk("abort busy", a_busy, 0);
        chk("abort mask", a_mask, 0);
        chk("abort cal_ok", a_ok, 0);
        chk("abort done", a_done, 0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0);
            if (a_done || a_busy) seen++;
        end
        chk("abort quiet", seen, 0);
        sweep(16'h0000, 0, -1, 1'b0, -1, lat);
        chk("post-abort latency", lat, LAT);
        chk("post-abort mask", a_mask, 16'hFFFF);
        chk("post-abort best", a_best, 7);
        step(1'b0);

        sweep(16'h0000, 0, 16 * P + 5, 1'b1, -1, lat);
        chk("pick reset stop", lat, -2);
        chk("pick reset busy", a_busy, 0);
        chk("pick reset done", a_done, 0);
        chk("pick reset cal_ok", a_ok, 0);
        chk("pick reset best", a_best, 0);
        chk("pick reset mask", a_mask, 0);
        chk("pick reset taps", {a_flop, a_comb}, 4'b0011);
        step(1'b0);

        sweep(16'h0000, 0, -1, 1'b0, 100, lat);
        chk("busy start latency", lat, LAT);
        chk("busy start mask", a_mask, 16'hFFFF);
        chk("busy start best", a_best, 7);

        en = 1'b0;
        step(1'b0);
        en = 1'b1;
        sweep(16'h0000, 0, 3, 1'b0, -1, lat);
        chk("abort apply busy", a_busy, 0);
        chk("abort apply cal_ok", a_ok, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tthbif_tap_cal.md
Name: tthbif_tap_cal

Overview:
- Calibration sequencer for the tthbif RX delay line.
- Steps all 16 RX tap codes, formed as `{flop_sel[1:0], comb_sel[1:0]}`.
- At each code: waits for the line to settle, then counts PRBS7 errors on one received lane over a fixed window and records pass/fail.
- Selects the centre of the longest passing run and drives it onto the tthbif RX tap selects.
- Sits between the register file (manual tap values, start/abort) and tthbif; the pass mask and status are read back through the register file.

Parameters:
- SETTLE_CYCLES, 16: cycles held in APPLY after each tap change; must be ≥ 8 so the checker history refills.
- WINDOW_CYCLES, 256: cycles of error counting per code.
- ERR_THRESH, 0: a code passes if its error count ≤ ERR_THRESH.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- en_i  in  1  global enable; low forces IDLE
- start_i  in  1  single-cycle pulse; starts a sweep (honoured in IDLE only)
- abort_i  in  1  single-cycle pulse; abandons a sweep
- rx_bit_i  in  1  sampled lane data from tthbif
- man_comb_sel_i  in  2  manual RX comb tap, from rf
- man_flop_sel_i  in  2  manual RX flop tap, from rf
- rx_comb_tap_sel_o  out  2  to tthbif
- rx_flop_tap_sel_o  out  2  to tthbif
- busy_o  out  1  high in APPLY/MEASURE/EVAL/PICK
- done_o  out  1  one-cycle pulse at sweep end
- cal_ok_o  out  1  a valid calibrated code is held
- best_code_o  out  4  selected code
- pass_mask_o  out  16  bit i = code i passed

Behaviour:
- Reset (`rst_ni` = 0 at a clock edge): state IDLE; all counters 0; `busy_o`, `done_o`, `cal_ok_o` = 0; `best_code_o` = 0; `pass_mask_o` = 0. Reset mid-sweep gives the same result; tap outputs then follow the manual inputs.
- Tap output mux:
  - busy: taps = current sweep code.
  - else if `cal_ok_o`: taps = `best_code_o`.
  - else: taps = manual inputs, combinationally.
- FSM states: IDLE, APPLY, MEASURE, EVAL, PICK, DONE.
  - IDLE → APPLY on `start_i && en_i`. Clears `pass_mask`, `cal_ok`, code = 0, settle counter.
  - APPLY: lasts exactly SETTLE_CYCLES cycles; the checker history is flushed on entry. Then MEASURE with the error counter cleared.
  - MEASURE: lasts exactly WINDOW_CYCLES cycles. The error counter increments when the checker flags an error and saturates at all-ones; width is `clog2(WINDOW_CYCLES+1)`.
  - EVAL (1 cycle): `pass_mask[code] <= (err ≤ ERR_THRESH)`. If code = 15, go to PICK; else code++ and go to APPLY.
  - PICK (16 cycles): scans i = 0..15, one bit per cycle, in linear order with no wrap-around.
    - Tracks the current run start/length and the best run start/length.
    - A run replaces the best only if strictly longer, so ties keep the lowest start.
    - Then DONE.
  - DONE (1 cycle):
    - If best length > 0: `best_code_o = best_start + (best_len−1)>>1` and `cal_ok_o = 1`.
    - Otherwise `cal_ok_o = 0` and `best_code_o` is unchanged.
    - `done_o = 1`; next state IDLE.
- Sweep latency from `start_i` to `done_o`: `16·(SETTLE_CYCLES+WINDOW_CYCLES+1) + 16 + 1` cycles.
- Abort: `abort_i`, or `en_i` low, in any non-IDLE state → IDLE next cycle. Clears `cal_ok_o` and `pass_mask_o`; no `done_o` pulse. If abort and start coincide, abort wins.
- `start_i` while busy is ignored.
- Checker (PRBS7, x^7+x^6+1, self-synchronising):
  - Shifts `rx_bit_i` into a 7-bit history `h`; the predicted bit is `h[6]^h[5]`.
  - The error flag is valid only after 7 bits have been shifted in since the last flush; this is guaranteed inside MEASURE by the SETTLE_CYCLES ≥ 8 constraint.

Decomposition:
- Package `tthbif_cal_pkg`:
  - state enum `cal_state_e`
  - `NUM_TAP_CODES` = 16
  - `TAP_CODE_W` = 4
  - `PRBS7_TAPS` constant
  - helper function splitting a code into flop/comb fields.
- Sub-module `prbs7_chk`: ports `clk_i`, `rst_ni`, `flush_i`, `bit_i`, `err_o`, `locked_o`.
- FSM, counters and run scanner live in `tthbif_tap_cal`.

Test Plan:
- Clean PRBS7 on all codes, SETTLE=16, WINDOW=32 → `pass_mask_o` = 0xFFFF, `best_code_o` = 7, `cal_ok_o` = 1, taps = flop 1 / comb 3, `done_o` at cycle 16·49+17 = 801 after start.
- Bench inverts every 5th bit except for codes 5..9 → mask = 0x03E0, best = 7; codes 2..4 and 10..13 pass → mask = 0x3C1C, best = 11 (run of length 4 wins over length 3).
- All codes corrupted → mask = 0, `cal_ok_o` = 0, taps track `man_*` inputs (set 2/1, then change to 0/3 and see the output follow in the same cycle).
- ERR_THRESH = 2, exactly 2 injected errors on code 0 → bit 0 set; 3 errors → bit 0 clear.
- `abort_i` during MEASURE of code 6 → IDLE next cycle, no `done_o`, mask = 0, `busy_o` = 0; a following `start_i` completes a full sweep normally.
- Reset asserted mid-PICK, and separately `start_i` pulsed while busy → all outputs return to reset values / the pulse is ignored, and sweep timing is unchanged.
